// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the multicycle ARM control unit: state encoding, opcode and
// ALU command codes, datapath selector values, condition codes and the control bundle.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_t;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic       nz_en;
    logic       cv_en;
  } ctrl_t;

endpackage

// File: rtl/condcheck.sv
// ARM condition-code evaluator: decides whether an instruction executes given NZCV.
module condcheck
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flopenr.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
module flopenr #(
  parameter int               WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q_o <= RST_VAL;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle ARM control unit: sequences fetch/decode/execute/memory/writeback, owns the
// NZCV flags and gates every architectural write with the condition latched at decode.
module mc_ctrl_fsm
  import arm_ctrl_pkg::*;
#(
  parameter state_t     RESET_STATE = S_FETCH,
  parameter logic [3:0] FLAG_RESET  = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  state_t     state_q, state_d;
  logic       condex_q;
  logic       cond_ex;
  logic [1:0] nz_q, cv_q;
  ctrl_t      ctrl, ctrl_out;

  logic       is_imm, s_l, u_bit, rd_pc;
  logic [3:0] cmd;
  logic [1:0] alu_op;
  logic       alu_known, alu_arith, is_cmp, dp_writes;

  assign is_imm    = Funct[5];
  assign cmd       = Funct[4:1];
  assign u_bit     = Funct[3];
  assign s_l       = Funct[0];
  assign rd_pc     = (Rd == 4'hF);
  assign dp_writes = alu_known & ~is_cmp;

  condcheck u_condcheck (
    .cond_i   (Cond),
    .flags_i  (Flags),
    .cond_ex_o(cond_ex)
  );

  // Unrecognised commands still run through the ALU as ADD but write nothing.
  always_comb begin
    alu_op    = ALU_ADD;
    alu_known = 1'b1;
    alu_arith = 1'b1;
    is_cmp    = 1'b0;
    case (cmd)
      CMD_ADD: alu_op = ALU_ADD;
      CMD_SUB: alu_op = ALU_SUB;
      CMD_AND: begin alu_op = ALU_AND; alu_arith = 1'b0; end
      CMD_ORR: begin alu_op = ALU_ORR; alu_arith = 1'b0; end
      CMD_CMP: begin alu_op = ALU_SUB; is_cmp = 1'b1; end
      default: begin alu_known = 1'b0; alu_arith = 1'b0; end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RESET_STATE;
      condex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) condex_q <= cond_ex;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = S_FETCH;
    ctrl         = '0;
    ctrl.imm_src = Op;
    ctrl.reg_src = {(Op == OP_MEM) & ~s_l, (Op == OP_B)};
    case (state_q)
      S_FETCH: begin
        state_d         = S_DECODE;
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
        ctrl.pc_write   = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = is_imm ? S_EXECI : S_EXECR;
          OP_B:    state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        state_d          = s_l ? S_MEMRD : S_MEMWR;
        ctrl.alu_src_b   = SRCB_EXTIMM;
        ctrl.alu_control = u_bit ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: begin
        state_d      = S_MEMWB;
        ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = condex_q & ~rd_pc;
        ctrl.pc_write   = condex_q & rd_pc;
      end
      S_MEMWR: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = condex_q;
      end
      S_EXECR, S_EXECI: begin
        state_d          = S_ALUWB;
        ctrl.alu_src_b   = (state_q == S_EXECI) ? SRCB_EXTIMM : SRCB_RD2;
        ctrl.alu_control = alu_op;
        ctrl.nz_en       = condex_q & alu_known & (s_l | is_cmp);
        ctrl.cv_en       = condex_q & alu_known & (s_l | is_cmp) & alu_arith;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = condex_q & dp_writes & ~rd_pc;
        ctrl.pc_write   = condex_q & dp_writes & rd_pc;
      end
      S_BRANCH: begin
        ctrl.alu_src_b  = SRCB_EXTIMM;
        ctrl.result_src = RES_ALURESULT;
        ctrl.pc_write   = condex_q;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Asserting reset kills every strobe combinationally, so an aborted cycle writes nothing.
  assign ctrl_out = reset ? ctrl : '0;

  flopenr #(.WIDTH(2), .RST_VAL(FLAG_RESET[3:2])) u_flag_nz (
    .clk  (clk),
    .rst_n(reset),
    .en_i (ctrl_out.nz_en),
    .d_i  (ALUFlags[3:2]),
    .q_o  (nz_q)
  );

  flopenr #(.WIDTH(2), .RST_VAL(FLAG_RESET[1:0])) u_flag_cv (
    .clk  (clk),
    .rst_n(reset),
    .en_i (ctrl_out.cv_en),
    .d_i  (ALUFlags[1:0]),
    .q_o  (cv_q)
  );

  assign PCWrite    = ctrl_out.pc_write;
  assign AdrSrc     = ctrl_out.adr_src;
  assign MemWrite   = ctrl_out.mem_write;
  assign IRWrite    = ctrl_out.ir_write;
  assign RegWrite   = ctrl_out.reg_write;
  assign ResultSrc  = ctrl_out.result_src;
  assign ALUSrcA    = ctrl_out.alu_src_a;
  assign ALUSrcB    = ctrl_out.alu_src_b;
  assign ALUControl = ctrl_out.alu_control;
  assign ImmSrc     = ctrl_out.imm_src;
  assign RegSrc     = ctrl_out.reg_src;
  assign Flags      = {nz_q, cv_q};
  assign State      = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed ISA scenarios plus random instructions
// checked against an instruction-level model of cycle counts, write pulses and flags.
module tb_mc_ctrl_fsm;
  import arm_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] Flags, State;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] model_flags;
  logic [1:0] wb_rs;
  logic       wb_pcw, wb_regw;
  logic [3:0] cmds [6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b0111};

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .Flags(Flags), .State(State)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ARM rule: cond[3:1] picks a base test, cond[0] inverts it; 1110 always, 1111 never.
  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit base;
    case (c[3:1])
      3'd0:    base = f[2];
      3'd1:    base = f[1];
      3'd2:    base = f[3];
      3'd3:    base = f[0];
      3'd4:    base = f[1] && !f[2];
      3'd5:    base = (f[3] == f[0]);
      3'd6:    base = !f[2] && (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    if (c == 4'hE) return 1'b1;
    return base ^ c[0];
  endfunction

  function automatic logic [3:0] alu_nzcv(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] ctl);
    logic [32:0] sum;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0;
    case (ctl)
      2'd0: begin
        sum = {1'b0, a} + {1'b0, b};
        r = sum[31:0]; c = sum[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      2'd1: begin
        sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = sum[31:0]; c = sum[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    return {r[31], (r == 32'd0), c, v};
  endfunction

  // Runs one instruction from FETCH back to FETCH and checks it against the model.
  task automatic run_instr(input string tag, input logic [3:0] cond, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd,
                           input logic [31:0] a, input logic [31:0] b);
    int         cycles, pcw, regw, memw, irw, exp_cycles, exp_pcw, exp_regw, exp_memw;
    bit         exec, is_dp, is_b, is_ldr, is_str, known, arith, cmp, writes;
    logic [1:0] ctl, exp_srcb, exp_rs, ctl_seen, srcb_seen, imm_seen;
    logic [3:0] exec_flags, exp_flags;

    exec   = cond_pass(cond, model_flags);
    is_dp  = (op == 2'b00);
    is_b   = (op == 2'b10);
    is_ldr = (op == 2'b01) && funct[0];
    is_str = (op == 2'b01) && !funct[0];
    known = 1'b1; arith = 1'b1; cmp = 1'b0; ctl = 2'd0;
    if (op == 2'b01) ctl = funct[3] ? 2'd0 : 2'd1;
    else if (is_dp) begin
      case (funct[4:1])
        4'b0100: ctl = 2'd0;
        4'b0010: ctl = 2'd1;
        4'b0000: begin ctl = 2'd2; arith = 1'b0; end
        4'b1100: begin ctl = 2'd3; arith = 1'b0; end
        4'b1010: begin ctl = 2'd1; cmp = 1'b1; end
        default: begin known = 1'b0; arith = 1'b0; end
      endcase
    end
    exec_flags = alu_nzcv(a, b, ctl);
    exp_cycles = is_dp ? 4 : is_ldr ? 5 : is_str ? 4 : is_b ? 3 : 2;
    writes     = is_dp && known && !cmp;
    exp_pcw    = 1 + ((exec && (is_b || (rd == 4'hF && (is_ldr || writes)))) ? 1 : 0);
    exp_regw   = (exec && rd != 4'hF && (is_ldr || writes)) ? 1 : 0;
    exp_memw   = (exec && is_str) ? 1 : 0;
    exp_srcb   = (is_dp && !funct[5]) ? 2'b00 : 2'b01;
    exp_rs     = is_dp ? 2'b00 : is_ldr ? 2'b01 : 2'b10;
    exp_flags  = model_flags;
    if (is_dp && exec && known && (funct[0] || cmp)) begin
      exp_flags[3:2] = exec_flags[3:2];
      if (arith) exp_flags[1:0] = exec_flags[1:0];
    end

    Cond = cond; Op = op; Funct = funct; Rd = rd;
    cycles = 0; pcw = 0; regw = 0; memw = 0; irw = 0;
    ctl_seen = 2'b00; srcb_seen = 2'b00; imm_seen = 2'b00;
    do begin
      ALUFlags = (cycles == 2) ? exec_flags : 4'($urandom);
      @(negedge clk);
      pcw  += PCWrite  ? 1 : 0;
      regw += RegWrite ? 1 : 0;
      memw += MemWrite ? 1 : 0;
      irw  += IRWrite  ? 1 : 0;
      if (cycles == 1) imm_seen = ImmSrc;
      if (cycles == 2) begin ctl_seen = ALUControl; srcb_seen = ALUSrcB; end
      wb_rs = ResultSrc; wb_pcw = PCWrite; wb_regw = RegWrite;
      cycles++;
      @(posedge clk); #1;
    end while (State != S_FETCH && cycles < 10);

    check({tag, ":cycles"}, cycles, exp_cycles);
    check({tag, ":pcwrite"}, pcw, exp_pcw);
    check({tag, ":regwrite"}, regw, exp_regw);
    check({tag, ":memwrite"}, memw, exp_memw);
    check({tag, ":irwrite"}, irw, 1);
    check({tag, ":immsrc"}, imm_seen, op);
    check({tag, ":flags"}, Flags, exp_flags);
    if (exp_cycles > 2) begin
      check({tag, ":aluctl"}, ctl_seen, ctl);
      check({tag, ":alusrcb"}, srcb_seen, exp_srcb);
      if (!is_str) check({tag, ":resultsrc"}, wb_rs, exp_rs);
    end
    model_flags = exp_flags;
  endtask

  initial begin
    logic [3:0]  r_cond;
    logic [1:0]  r_op;
    logic [5:0]  r_funct;
    logic [31:0] r_a, r_b;

    reset = 1'b0; Cond = 4'h0; Op = 2'b00; Funct = 6'h00; Rd = 4'h0; ALUFlags = 4'h0;
    model_flags = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst:state", State, S_FETCH);
    check("rst:flags", Flags, 4'b0000);
    check("rst:pcwrite", PCWrite, 1'b0);
    check("rst:irwrite", IRWrite, 1'b0);
    check("rst:regwrite", RegWrite, 1'b0);
    check("rst:memwrite", MemWrite, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    run_instr("adds", 4'hE, 2'b00, 6'b001001, 4'd1, 32'h1, 32'hFFFF_FFFF);
    check("adds:flagvalue", Flags, 4'b0110);

    run_instr("cmp", 4'hE, 2'b00, 6'b010101, 4'd0, 32'h5, 32'h5);
    check("cmp:zset", Flags[2], 1'b1);
    run_instr("beq", 4'h0, 2'b10, 6'b000000, 4'd0, 32'h0, 32'h0);
    check("beq:taken", wb_pcw, 1'b1);

    run_instr("strne", 4'h1, 2'b01, 6'b011000, 4'd2, 32'h100, 32'h4);

    run_instr("ldrpc", 4'hE, 2'b01, 6'b011001, 4'hF, 32'h200, 32'h0);
    check("ldrpc:wbpcw", wb_pcw, 1'b1);
    check("ldrpc:wbregw", wb_regw, 1'b0);
    check("ldrpc:wbrs", wb_rs, 2'b01);

    run_instr("adds_cv", 4'hE, 2'b00, 6'b001001, 4'd4, 32'h8000_0000, 32'h8000_0000);
    check("adds_cv:flagvalue", Flags, 4'b0111);
    run_instr("ands", 4'hE, 2'b00, 6'b000001, 4'd5, 32'hF000_0000, 32'h8000_0000);
    check("ands:flagvalue", Flags, 4'b1011);

    run_instr("illegal", 4'hE, 2'b11, 6'b001001, 4'd1, 32'h1, 32'h1);

    Cond = 4'hE; Op = 2'b01; Funct = 6'b011001; Rd = 4'd3; ALUFlags = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort:inmemrd", State, S_MEMRD);
    reset = 1'b0;
    #1;
    check("abort:state", State, S_FETCH);
    check("abort:flags", Flags, 4'b0000);
    check("abort:pcwrite", PCWrite, 1'b0);
    check("abort:regwrite", RegWrite, 1'b0);
    check("abort:memwrite", MemWrite, 1'b0);
    check("abort:irwrite", IRWrite, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_flags = 4'b0000;

    for (int i = 0; i < 60; i++) begin
      r_cond = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom);
      r_op   = 2'($urandom);
      if (r_op == 2'b00) r_funct = {1'($urandom), cmds[$urandom_range(0, 5)], 1'($urandom)};
      else               r_funct = 6'($urandom);
      r_a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 2));
      r_b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 2));
      run_instr("rand", r_cond, r_op, r_funct, 4'($urandom), r_a, r_b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
